icache_fetch: RTL and testbench

- Direct-mapped, read-only instruction cache directly upstream of the fetch stage.
- Fetch stage drives the word address; this block returns the instruction word combinationally in the same cycle and raises stall on a miss.
- A miss is refilled a whole line at a time from a single-beat request/valid memory port.
- Fetch holds its PC while stall is high.

---
 rtl/icache_pkg.sv | 24 ++
 rtl/icache_refill_ctrl.sv | 76 +++++++
 rtl/icache_fetch.sv | 109 ++++++++++
 tb/tb_icache_fetch.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/icache_pkg.sv
// Shared types, constants and address-split helpers for the direct-mapped instruction cache.
package icache_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        REFILL = 1'b1
    } state_t;

    localparam logic [31:0] NOP_WORD = 32'h0;

    // Word offset within a line; upper bits of the result are always zero.
    function automatic logic [31:0] addr_offset(input logic [31:0] a, input int words);
        return (a >> 2) & (words - 1);
    endfunction

    function automatic logic [31:0] addr_index(input logic [31:0] a, input int lines, input int words);
        return (a >> (2 + $clog2(words))) & (lines - 1);
    endfunction

    function automatic logic [31:0] addr_tag(input logic [31:0] a, input int lines, input int words);
        return a >> (2 + $clog2(words) + $clog2(lines));
    endfunction

endpackage

// File: rtl/icache_refill_ctrl.sv
// Refill sequencer: FSM, word counter, drop flag and single-beat memory handshake for one line.
module icache_refill_ctrl
    import icache_pkg::*;
#(
    parameter int LINES = 16,
    parameter int WORDS = 4,
    localparam int OB = $clog2(WORDS),
    localparam int IB = $clog2(LINES),
    localparam int TW = 30 - OB - IB
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [29-OB:0]  line_sel,
    input  logic            inv,
    input  logic            mem_valid,
    output logic            idle,
    output logic            mem_req,
    output logic [31:0]     mem_addr,
    output logic            wr_en,
    output logic [IB-1:0]   wr_index,
    output logic [OB-1:0]   wr_offset,
    output logic [TW-1:0]   wr_tag,
    output logic            commit
);

    state_t          state_q, state_d;
    logic [OB-1:0]   cnt_q;
    logic [29-OB:0]  base_q;
    logic            drop_q;
    logic            last_beat;

    assign idle      = (state_q == IDLE);
    assign mem_req   = (state_q == REFILL);
    assign mem_addr  = mem_req ? {base_q, cnt_q, 2'b00} : 32'h0;
    assign wr_en     = mem_req && mem_valid;
    assign wr_index  = base_q[IB-1:0];
    assign wr_offset = cnt_q;
    assign wr_tag    = base_q[29-OB:IB];
    assign last_beat = wr_en && (&cnt_q);
    // An invalidate landing on the final beat must also keep the line invalid.
    assign commit    = last_beat && !drop_q && !inv;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = REFILL;
            REFILL:  if (last_beat) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            base_q  <= '0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE) begin
                if (start) begin
                    base_q <= line_sel;
                    cnt_q  <= '0;
                    drop_q <= 1'b0;
                end
            end else begin
                // Counter is exactly OB bits, so it wraps to zero on the last beat.
                if (wr_en) cnt_q <= cnt_q + OB'(1);
                if (last_beat) drop_q <= 1'b0;
                else if (inv) drop_q <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/icache_fetch.sv
// Direct-mapped read-only instruction cache in front of fetch; combinational hit path, line refill on miss.
// Optional hit/miss counters are built when ICACHE_STATS_EN is defined.
module icache_fetch
    import icache_pkg::*;
#(
    parameter int LINES = 16,
    parameter int WORDS = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic [31:0] addr,
    input  logic        inv,
    output logic [31:0] rdata,
    output logic        stall,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_valid,
    input  logic [31:0] mem_rdata
`ifdef ICACHE_STATS_EN
    ,
    output logic [31:0] hit_cnt,
    output logic [31:0] miss_cnt
`endif
);

    localparam int OB = $clog2(WORDS);
    localparam int IB = $clog2(LINES);
    localparam int TW = 30 - OB - IB;

    logic [31:0]    off_full, idx_full, tag_full;
    logic [OB-1:0]  off;
    logic [IB-1:0]  idx;
    logic [TW-1:0]  tag;
    logic           unused_bits;

    logic [LINES-1:0] valid_q;
    logic [TW-1:0]    tag_mem  [LINES];
    logic [31:0]      data_mem [LINES][WORDS];

    logic           idle, hit, start;
    logic           wr_en, commit;
    logic [IB-1:0]  wr_index;
    logic [OB-1:0]  wr_offset;
    logic [TW-1:0]  wr_tag;

    assign off_full    = addr_offset(addr, WORDS);
    assign idx_full    = addr_index(addr, LINES, WORDS);
    assign tag_full    = addr_tag(addr, LINES, WORDS);
    assign off         = off_full[OB-1:0];
    assign idx         = idx_full[IB-1:0];
    assign tag         = tag_full[TW-1:0];
    assign unused_bits = ^{off_full[31:OB], idx_full[31:IB], tag_full[31:TW], addr[1:0]};

    // Lookup only counts in IDLE; addr and en are don't-care while a refill runs.
    assign hit   = en && idle && valid_q[idx] && (tag_mem[idx] == tag);
    assign start = en && idle && !hit;
    assign stall = en && !hit;
    assign rdata = hit ? data_mem[idx][off] : NOP_WORD;

    icache_refill_ctrl #(
        .LINES (LINES),
        .WORDS (WORDS)
    ) u_refill (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .line_sel  (addr[31:OB+2]),
        .inv       (inv),
        .mem_valid (mem_valid),
        .idle      (idle),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .wr_en     (wr_en),
        .wr_index  (wr_index),
        .wr_offset (wr_offset),
        .wr_tag    (wr_tag),
        .commit    (commit)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= '0;
        end else if (inv) begin
            valid_q <= '0;
        end else if (commit) begin
            valid_q[wr_index] <= 1'b1;
        end
    end

    // Tag and data arrays carry no reset; the valid bits guard them.
    always_ff @(posedge clk) begin
        if (wr_en) data_mem[wr_index][wr_offset] <= mem_rdata;
        if (commit) tag_mem[wr_index] <= wr_tag;
    end

`ifdef ICACHE_STATS_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else begin
            if (hit) hit_cnt <= hit_cnt + 32'd1;
            if (start) miss_cnt <= miss_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_icache_fetch.sv
// Self-checking bench for icache_fetch: directed scenarios plus randomized traffic against a cache-contents model.
module tb_icache_fetch;

    localparam int LINES = 16;
    localparam int WORDS = 4;

    logic        clk;
    logic        reset;
    logic        en;
    logic [31:0] addr;
    logic        inv;
    logic [31:0] rdata;
    logic        stall;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_valid;
    logic [31:0] mem_rdata;
`ifdef ICACHE_STATS_EN
    logic [31:0] hit_cnt;
    logic [31:0] miss_cnt;
`endif

    icache_fetch #(
        .LINES (LINES),
        .WORDS (WORDS)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .addr      (addr),
        .inv       (inv),
        .rdata     (rdata),
        .stall     (stall),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_valid (mem_valid),
        .mem_rdata (mem_rdata)
`ifdef ICACHE_STATS_EN
        ,
        .hit_cnt   (hit_cnt),
        .miss_cnt  (miss_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model: the cache holds exact copies of backing memory, so only valid/tag per line matter.
    bit          mvalid [LINES];
    int unsigned mtag   [LINES];
    logic [31:0] req_q  [$];
    int unsigned ridx, rtag;
    bit          drop;
    int          wait_left;
    int          lat;
    bit          rand_lat;
    bit          exp_hit, exp_stall;
    logic [31:0] m_hits, m_misses;

    function automatic logic [31:0] memfn(input logic [31:0] a);
        if (a < 32'h1000) return 32'hA0 + (a >> 2);
        return a ^ 32'hC3A5_5A3C;
    endfunction

    function automatic logic [31:0] genAddr();
        logic [31:0] t;
        case ($urandom % 4)
            0:       t = 32'h0;
            1:       t = 32'h1;
            2:       t = 32'h2;
            default: t = 32'hFF_FFFF;
        endcase
        return (t << 8) | (($urandom % 4) << 4) | ($urandom % 16);
    endfunction

    task automatic modelReset();
        for (int i = 0; i < LINES; i++) mvalid[i] = 1'b0;
        req_q.delete();
        drop      = 1'b0;
        wait_left = 0;
        exp_hit   = 1'b0;
        exp_stall = 1'b0;
        m_hits    = 32'h0;
        m_misses  = 32'h0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic checkOutput();
        int unsigned idx, tg;
        bit          idle;
        idx  = (addr / (4 * WORDS)) % LINES;
        tg   = addr / (4 * WORDS * LINES);
        idle = (req_q.size() == 0);
        exp_hit   = en && idle && mvalid[idx] && (mtag[idx] == tg);
        exp_stall = en && !exp_hit;
        chk("rdata", rdata, exp_hit ? memfn({addr[31:2], 2'b00}) : 32'h0);
        chk("stall", {31'b0, stall}, {31'b0, exp_stall});
        chk("mem_req", {31'b0, mem_req}, {31'b0, !idle});
        chk("mem_addr", mem_addr, idle ? 32'h0 : req_q[0]);
`ifdef ICACHE_STATS_EN
        chk("hit_cnt", hit_cnt, m_hits);
        chk("miss_cnt", miss_cnt, m_misses);
`endif
    endtask

    task automatic modelUpdate();
        bit was_refill, beat, last;
        int unsigned base;
        if (reset) begin
            modelReset();
            return;
        end
        was_refill = (req_q.size() != 0);
        beat       = was_refill && mem_valid;
        last       = beat && (req_q.size() == 1);
        if (exp_hit) m_hits++;
        if (beat) begin
            void'(req_q.pop_front());
            if (last) begin
                if (!drop && !inv) begin
                    mvalid[ridx] = 1'b1;
                    mtag[ridx]   = rtag;
                end
                drop = 1'b0;
            end else begin
                wait_left = lat;
            end
        end else if (was_refill && wait_left > 0) begin
            wait_left--;
        end
        if (inv) begin
            for (int i = 0; i < LINES; i++) mvalid[i] = 1'b0;
            if (was_refill && !last) drop = 1'b1;
        end
        if (!was_refill && en && !exp_hit) begin
            base = addr & ~(4 * WORDS - 1);
            for (int k = 0; k < WORDS; k++) req_q.push_back(base + 4 * k);
            ridx = (addr / (4 * WORDS)) % LINES;
            rtag = addr / (4 * WORDS * LINES);
            drop = 1'b0;
            if (rand_lat) lat = $urandom_range(3, 0);
            wait_left = lat;
            m_misses++;
        end
    endtask

    // One fetch cycle: drive at the falling edge, check 1 ns later, advance the model.
    task automatic applyStimulus(input logic e, input logic [31:0] a, input logic i, input bit junk);
        @(negedge clk);
        en   = e;
        addr = a;
        inv  = i;
        if (req_q.size() != 0) begin
            mem_valid = (wait_left == 0);
            mem_rdata = memfn(req_q[0]);
        end else begin
            mem_valid = junk ? 1'($urandom % 2) : 1'b0;
            mem_rdata = $urandom;
        end
        #1;
        checkOutput();
        modelUpdate();
    endtask

    task automatic fetchUntilHit(input logic [31:0] a);
        int n;
        n = 0;
        applyStimulus(1'b1, a, 1'b0, 1'b0);
        while (stall && n < 200) begin
            applyStimulus(1'b1, a, 1'b0, 1'b0);
            n++;
        end
        chk("fetch_timeout", 32'(n < 200), 32'h1);
    endtask

    logic [31:0] cur_addr;
    logic        cur_en, cur_inv;

    initial begin
        reset = 1'b1; en = 1'b0; addr = 32'h0; inv = 1'b0;
        mem_valid = 1'b0; mem_rdata = 32'h0;
        lat = 0; rand_lat = 1'b0;
        modelReset();
        repeat (2) applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
        reset = 1'b0;

        $display("[TB] cold miss and hits");
        fetchUntilHit(32'h0);
        applyStimulus(1'b1, 32'h8, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'hC, 1'b0, 1'b0);

        $display("[TB] conflict eviction");
        fetchUntilHit(32'h100);
        fetchUntilHit(32'h0);

        $display("[TB] slow memory");
        lat = 3;
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
        fetchUntilHit(32'h20);
        applyStimulus(1'b1, 32'h24, 1'b0, 1'b0);

        $display("[TB] reset during refill");
        lat = 0;
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
        applyStimulus(1'b1, 32'h0, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'h0, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'h0, 1'b0, 1'b0);
        @(posedge clk);
        #2;
        reset = 1'b1;
        modelReset();
        #1;
        checkOutput();
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
        reset = 1'b0;
        fetchUntilHit(32'h0);

        $display("[TB] invalidate during refill");
        applyStimulus(1'b1, 32'h40, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'h40, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'h40, 1'b1, 1'b0);
        fetchUntilHit(32'h40);

        $display("[TB] wrap-around line at top of memory");
        fetchUntilHit(32'hFFFF_FFF4);
        applyStimulus(1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0);

        $display("[TB] randomized traffic");
        rand_lat = 1'b1;
        cur_en = 1'b0; cur_addr = 32'h0;
        for (int c = 0; c < 3000; c++) begin
            if (!exp_stall) begin
                cur_en   = ($urandom % 8) != 0;
                cur_addr = genAddr();
            end
            cur_inv = ($urandom % 32) == 0;
            applyStimulus(cur_en, cur_addr, cur_inv, 1'b1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
